// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - register-file controller for the serial side of an I2C slave
// Bytes are assembled/served bit-serially MSB first; the register file is exposed in parallel.
module i2c_reg_ctrl #(
  parameter int          NREGS   = 8,
  parameter logic [7:0]  RST_VAL = 8'h00,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 sde_in,
  input  logic                 sd_in,
  input  logic                 dl_in,
  input  logic                 ul_in,
  output logic                 sd_out,
  output logic [NREGS*8-1:0]   cfg_out,
  output logic                 wr_out,
  output logic [AW-1:0]        wr_addr_out,
  output logic                 err_out,
  input  logic                 clr_err_in
);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_DATA, S_TX} state_t;

  localparam logic [8:0] NREGS_9 = 9'(NREGS);

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_ptr;
  logic [3:0]      r_bitcnt;
  logic [7:0]      r_rx;
  logic [7:0]      r_tx;
  logic [7:0]      r_regs [NREGS];

  logic w_dl, w_ul, w_sde;
  logic w_rx_state, w_full, w_dl_ok, w_ptr_ok, w_wr, w_shift, w_err_set;

  // One event per cycle, by priority start > dl > ul > sde.
  assign w_dl  = dl_in && !start_in;
  assign w_ul  = ul_in && !start_in && !dl_in;
  assign w_sde = sde_in && !start_in && !dl_in && !ul_in;

  assign w_rx_state = (r_state == S_PTR) || (r_state == S_DATA);
  assign w_full     = (r_bitcnt == 4'd8);
  assign w_dl_ok    = w_dl && w_rx_state && w_full;
  assign w_ptr_ok   = ({1'b0, r_rx} < NREGS_9);
  assign w_wr       = w_dl_ok && (r_state == S_DATA);
  assign w_shift    = w_sde && (r_state != S_IDLE) && !w_full;

  // A dropped upload (dl_in wins) is reported, as is any malformed download.
  assign w_err_set = (w_dl && !w_dl_ok)
                   || (w_dl_ok && (r_state == S_PTR) && !w_ptr_ok)
                   || (w_dl && ul_in)
                   || (w_sde && w_rx_state && w_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start_in)                            w_next = S_PTR;
    else if (w_dl_ok && r_state == S_PTR)    w_next = S_DATA;
    else if (w_ul)                           w_next = S_TX;
  end

  always_comb begin
    sd_out = (r_state == S_TX) ? r_tx[7] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_bitcnt    <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      wr_out      <= 1'b0;
      wr_addr_out <= '0;
      err_out     <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= RST_VAL;
    end else begin
      wr_out <= w_wr;
      if (w_err_set)       err_out <= 1'b1;
      else if (clr_err_in) err_out <= 1'b0;

      if (start_in || w_dl || w_ul) r_bitcnt <= '0;
      else if (w_shift)             r_bitcnt <= r_bitcnt + 4'd1;

      if (w_shift && w_rx_state) r_rx <= {r_rx[6:0], sd_in};

      if (w_ul)                               r_tx <= r_regs[r_ptr];
      else if (w_shift && r_state == S_TX)    r_tx <= {r_tx[6:0], 1'b0};

      if (w_dl_ok && r_state == S_PTR) r_ptr <= w_ptr_ok ? r_rx[AW-1:0] : '0;
      else if (w_wr || w_ul)           r_ptr <= r_ptr + AW'(1);

      if (w_wr) begin
        r_regs[r_ptr] <= r_rx;
        wr_addr_out   <= r_ptr;
      end
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int i = 0; i < NREGS; i++) cfg_out[8*i +: 8] = r_regs[i];
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb/tb_i2c_reg_ctrl.sv - self-checking bench for i2c_reg_ctrl
module tb_i2c_reg_ctrl;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_in = 1'b0, sde_in = 1'b0, sd_in = 1'b0, dl_in = 1'b0, ul_in = 1'b0, clr_err_in = 1'b0;
  logic                sd_out, wr_out, err_out;
  logic [NREGS*8-1:0]  cfg_out;
  logic [AW-1:0]       wr_addr_out;

  i2c_reg_ctrl #(.NREGS(NREGS), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .sde_in(sde_in), .sd_in(sd_in),
    .dl_in(dl_in), .ul_in(ul_in), .sd_out(sd_out), .cfg_out(cfg_out),
    .wr_out(wr_out), .wr_addr_out(wr_addr_out), .err_out(err_out), .clr_err_in(clr_err_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [NREGS];
  int         m_ptr = 0;
  int         wq_addr [$];
  logic [7:0] wq_data [$];
  int         rq [$];

  function automatic logic [NREGS*8-1:0] model_cfg();
    logic [NREGS*8-1:0] v;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic cyc(input logic s, input logic sde, input logic sd, input logic dl,
                     input logic ul, input logic clr);
    start_in = s; sde_in = sde; sd_in = sd; dl_in = dl; ul_in = ul; clr_err_in = clr;
    @(posedge clk); #1;
    start_in = 0; sde_in = 0; sd_in = 0; dl_in = 0; ul_in = 0; clr_err_in = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, b[7-i], 0, 0, 0);
  endtask

  task automatic ptr_byte(input logic [7:0] b);
    send_bits(b, 8);
    m_ptr = (b < NREGS) ? int'(b) : 0;
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  task automatic expect_write(input logic [7:0] b);
    wq_addr.push_back(m_ptr);
    wq_data.push_back(b);
    m_regs[m_ptr] = b;
    m_ptr = (m_ptr + 1) % NREGS;
  endtask

  task automatic write_byte(input logic [7:0] b);
    send_bits(b, 8);
    expect_write(b);
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  // Write scoreboard: every wr_out pulse must match the oldest expected write.
  always @(negedge clk) begin : wr_mon
    int a;
    logic [7:0] d;
    if (!rst && wr_out) begin
      checks++;
      if (wq_addr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: wr_out=1 addr=%0d, no write expected", wr_addr_out);
      end else begin
        a = wq_addr.pop_front();
        d = wq_data.pop_front();
        if (wr_addr_out !== 3'(a) || cfg_out[8*a +: 8] !== d) begin
          failures++;
          $display("FAIL wr_scoreboard: addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr_out, cfg_out[8*a +: 8], a, d);
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    #23;
    checks++;
    if ({sd_out, wr_out, wr_addr_out, err_out} !== 6'b0 || cfg_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: sd=%b wr=%b addr=%0d err=%b cfg=%h, expected all 0",
               sd_out, wr_out, wr_addr_out, err_out, cfg_out);
    end
    @(posedge clk); #1; rst = 0;
    send_bits(8'h00, 8);
    checks++;
    if (err_out !== 1'b0) begin
      failures++; $display("FAIL idle_sde_err: err=%b, expected 0", err_out);
    end
    cyc(0, 0, 0, 1, 0, 0);
    checks++;
    if (err_out !== 1'b1) begin
      failures++; $display("FAIL idle_dl_err: err=%b, expected 1", err_out);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (err_out !== 1'b0) begin
      failures++; $display("FAIL clr_err: err=%b, expected 0", err_out);
    end
  endtask

  task automatic test_write();
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h03);
    write_byte(8'hA5);
    write_byte(8'h5A);
    checks++;
    if (cfg_out !== model_cfg() || err_out !== 1'b0) begin
      failures++;
      $display("FAIL write_cfg: cfg=%h err=%b, expected cfg=%h err=0", cfg_out, err_out, model_cfg());
    end
  endtask

  task automatic test_wrap();
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h07);
    write_byte(8'h11);
    write_byte(8'h22);
    checks++;
    if (cfg_out !== model_cfg() || err_out !== 1'b0) begin
      failures++;
      $display("FAIL wrap_cfg: cfg=%h err=%b, expected cfg=%h err=0", cfg_out, err_out, model_cfg());
    end
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h09);
    checks++;
    if (err_out !== 1'b1) begin
      failures++; $display("FAIL bad_ptr_err: err=%b, expected 1", err_out);
    end
    write_byte(8'h33);
    checks++;
    if (cfg_out !== model_cfg()) begin
      failures++; $display("FAIL bad_ptr_cfg: cfg=%h, expected %h", cfg_out, model_cfg());
    end
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic read_check(input string name, input int nstrobes);
    int e;
    for (int i = 0; i < nstrobes; i++) begin
      e = rq.pop_front();
      checks++;
      if (sd_out !== 1'(e)) begin
        failures++;
        $display("FAIL %s bit %0d: sd_out=%b, expected %0d", name, i, sd_out, e);
      end
      cyc(0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_read();
    logic [7:0] b;
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h03);
    for (int k = 0; k < 2; k++) begin
      b = m_regs[m_ptr];
      m_ptr = (m_ptr + 1) % NREGS;
      cyc(0, 0, 0, 0, 1, 0);
      for (int i = 7; i >= 0; i--) rq.push_back(int'(b[i]));
      read_check(k == 0 ? "read_a5" : "read_5a", 8);
    end
    rq.push_back(0);
    rq.push_back(0);
    read_check("read_extra", 2);
    checks++;
    if (sd_out !== 1'b0 || err_out !== 1'b0) begin
      failures++; $display("FAIL read_tail: sd=%b err=%b, expected 0 0", sd_out, err_out);
    end
  endtask

  task automatic test_errors();
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h01);
    send_bits(8'hFF, 5);
    cyc(0, 0, 0, 1, 0, 0);
    checks++;
    if (err_out !== 1'b1) begin
      failures++; $display("FAIL short_dl_err: err=%b, expected 1", err_out);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (err_out !== 1'b0) begin
      failures++; $display("FAIL short_dl_clr: err=%b, expected 0", err_out);
    end
    cyc(0, 0, 0, 1, 0, 1);
    checks++;
    if (err_out !== 1'b1) begin
      failures++; $display("FAIL set_beats_clr: err=%b, expected 1", err_out);
    end
    cyc(0, 0, 0, 0, 0, 1);
    send_bits(8'h12, 8);
    cyc(0, 1, 1, 0, 0, 0);
    checks++;
    if (err_out !== 1'b1) begin
      failures++; $display("FAIL ninth_strobe_err: err=%b, expected 1", err_out);
    end
    expect_write(8'h12);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    send_bits(8'h66, 8);
    expect_write(8'h66);
    cyc(0, 0, 0, 1, 1, 0);
    checks++;
    if (err_out !== 1'b1) begin
      failures++; $display("FAIL dl_ul_err: err=%b, expected 1", err_out);
    end
    cyc(0, 0, 0, 0, 0, 1);
    write_byte(8'h77);
    checks++;
    if (cfg_out !== model_cfg() || err_out !== 1'b0) begin
      failures++;
      $display("FAIL errors_cfg: cfg=%h err=%b, expected cfg=%h err=0", cfg_out, err_out, model_cfg());
    end
  endtask

  task automatic test_abort();
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h05);
    send_bits(8'hFF, 4);
    cyc(1, 0, 0, 0, 0, 0);
    checks++;
    if (err_out !== 1'b0) begin
      failures++; $display("FAIL abort_err: err=%b, expected 0", err_out);
    end
    ptr_byte(8'h02);
    write_byte(8'h44);
    checks++;
    if (cfg_out !== model_cfg() || err_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_cfg: cfg=%h err=%b, expected cfg=%h err=0", cfg_out, err_out, model_cfg());
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0, 0, 0);
    ptr_byte(8'h00);
    send_bits(8'hC3, 4);
    #3 rst = 1;
    #1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    checks++;
    if ({sd_out, wr_out, wr_addr_out, err_out} !== 6'b0 || cfg_out !== '0) begin
      failures++;
      $display("FAIL reset_mid: sd=%b wr=%b addr=%0d err=%b cfg=%h, expected all 0",
               sd_out, wr_out, wr_addr_out, err_out, cfg_out);
    end
    @(posedge clk); #1; rst = 0;
    send_bits(8'h0C, 4);
    cyc(0, 0, 0, 1, 0, 0);
    checks++;
    if (cfg_out !== model_cfg() || err_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_abort: cfg=%h err=%b, expected cfg=%h err=1", cfg_out, err_out, model_cfg());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_errors();
    test_abort();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wq_addr.size() != 0) begin
      failures++; $display("FAIL writes_missing: %0d pending, expected 0", wq_addr.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
Register-file controller that sequences the serial side of the I2C slave (sde/sd/ul/dl handshake).
- Write transfers: assembles received bits into bytes. The first byte of a frame is the register pointer; later bytes are data written at an auto-incrementing pointer.
- Read transfers: serves register bytes bit-serially back to the slave.
- Exposes the register file in parallel as configuration for the filter datapath.

Parameters:
NREGS, 8, number of 8-bit registers (power of two, 2..128); AW = clog2(NREGS) derived.
RST_VAL, 8'h00, reset value of every register.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start_in  input  1  one-cycle pulse: START/repeated START detected on bus
sde_in  input  1  one-cycle pulse: serial bit strobe from slave
sd_in  input  1  received bit from slave, valid when sde_in=1
dl_in  input  1  one-cycle pulse: slave finished receiving a byte (download)
ul_in  input  1  one-cycle pulse: slave requests next byte to transmit (upload)
sd_out  output  1  bit presented to slave for transmission
cfg_out  output  NREGS*8  register file, reg i at bits [8i+7:8i]
wr_out  output  1  one-cycle pulse: a register was written
wr_addr_out  output  AW  index written, valid with wr_out
err_out  output  1  sticky protocol error flag
clr_err_in  input  1  clears err_out (sync)

Behaviour:
- Reset (async, immediate): state=IDLE, ptr=0, bitcnt=0, rx/tx shift regs=0, all regs=RST_VAL, sd_out=0, wr_out=0, wr_addr_out=0, err_out=0. Reset mid-transfer aborts the transfer; no partial write.
- States: IDLE, PTR (expect pointer byte), DATA (expect data bytes), TX (serving read).
- Event priority per cycle: start_in > dl_in > ul_in > sde_in.
- start_in in any state -> PTR, bitcnt=0; ptr is kept. A byte in progress is discarded and no error is raised.
- Receive (PTR/DATA), sde_in:
  - rx <= {rx[6:0], sd_in} (MSB first).
  - bitcnt increments, saturating at 8.
  - A 9th strobe sets err_out and does not shift.
- dl_in with bitcnt==8, state PTR:
  - rx<NREGS: ptr<=rx[AW-1:0].
  - Otherwise: ptr<=0, err_out<=1.
  - Then -> DATA, bitcnt=0.
- dl_in with bitcnt==8, state DATA:
  - reg[ptr]<=rx; wr_out=1 and wr_addr_out=ptr in the next cycle (1-cycle latency); cfg_out updates in that same cycle.
  - ptr<=ptr+1 mod NREGS (NREGS-1 wraps to 0).
  - bitcnt=0.
- dl_in with bitcnt!=8, or dl_in in IDLE/TX: byte discarded, err_out<=1, bitcnt=0, state unchanged.
- ul_in in any state:
  - tx<=reg[ptr]; ptr<=ptr+1 mod NREGS; bitcnt=0; -> TX.
  - sd_out = tx[7] from the next cycle.
  - A register written by dl_in in the same cycle is not visible because dl_in wins; ul_in is then dropped and err_out<=1.
- TX, sde_in:
  - tx<=tx<<1; sd_out follows tx[7]; bitcnt increments.
  - After 8 strobes sd_out=0. Further strobes hold 0 and set no error (master NACK/extra clocks tolerated).
- IDLE: sde_in ignored.
- clr_err_in clears err_out unless a new error occurs in the same cycle; set wins.
- wr_out never asserts on two consecutive cycles without an intervening dl_in.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, cfg_out=all 8'h00; after release, 8 sde_in strobes with no start_in -> no state change.
- Write: start_in; bits 0x03; dl_in; bits 0xA5; dl_in; bits 0x5A; dl_in -> wr_out pulses with addr 3 then 4; cfg_out reg3=A5, reg4=5A; err_out=0.
- Wrap: start_in, ptr byte 0x07, data 0x11, 0x22 -> reg7=11, reg0=22 (NREGS=8); ptr byte 0x09 -> err_out=1, next data goes to reg0.
- Read: after the write test, start_in, ptr 0x03, dl_in, ul_in, 8 sde_in -> sd_out sequence 1,0,1,0,0,1,0,1; second ul_in serves 0x5A; 9th strobe -> sd_out=0, no error.
- Errors: dl_in after 5 bits -> err_out=1, no write; clr_err_in -> 0; ul_in and dl_in in the same cycle -> write occurs, err_out=1, state stays DATA.
- Abort: start_in after 4 data bits -> no write, state PTR, err_out stays 0; the next full byte is taken as the pointer.
